// File: rtl/gmem_arb_pkg.sv
// Shared types and helpers for the global-memory read arbiter.
package gmem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} gmem_arb_state_t;

  localparam int GMEM_ADDR_W = 28;
  localparam int GMEM_DATA_W = 32;
  localparam int GMEM_ID_W   = 4;

  // Wrap a requester index into 0..n-1 for the round-robin search.
  function automatic int rr_wrap(input int i, input int n);
    return (n > 0) ? (i % n) : 0;
  endfunction

endpackage

// File: rtl/gmem_rd_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request searching upward
// from ptr+1, wrapping. Outputs a one-hot grant and its index.
module rr_pick
  import gmem_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx
);

  int   j;
  logic found;

  // Scan N positions starting just after the last winner.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= N; k++) begin
      j = rr_wrap(int'(ptr) + k, N);
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = $clog2(N)'(j);
      end
    end
  end

endmodule

// File: rtl/gmem_rd_arbiter.sv
// Round-robin arbiter sharing one global_mem AXI read port among N_REQ
// requesters, one burst outstanding, with RLAST beat-count checking.
// Optional feature: define GMEM_ARB_STATS_EN to build saturating 16-bit
// per-requester grant counters; otherwise grant_cnt reads as zero.
module gmem_rd_arbiter
  import gmem_arb_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = GMEM_ADDR_W,
  parameter int DATA_W = GMEM_DATA_W,
  parameter int ID_W   = GMEM_ID_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ*ADDR_W-1:0] s_araddr,
  input  logic [N_REQ*8-1:0]      s_arlen,
  input  logic [N_REQ*ID_W-1:0]   s_arid,
  input  logic [N_REQ-1:0]        s_arvalid,
  output logic [N_REQ-1:0]        s_arready,
  output logic [DATA_W-1:0]       s_rdata,
  output logic [ID_W-1:0]         s_rid,
  output logic                    s_rlast,
  output logic [N_REQ-1:0]        s_rvalid,
  input  logic [N_REQ-1:0]        s_rready,
  output logic [ADDR_W-1:0]       m_araddr,
  output logic [7:0]              m_arlen,
  output logic [ID_W-1:0]         m_arid,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  input  logic [DATA_W-1:0]       m_rdata,
  input  logic [ID_W-1:0]         m_rid,
  input  logic                    m_rlast,
  input  logic                    m_rvalid,
  output logic                    m_rready,
  output logic                    burst_err,
  output logic [N_REQ*16-1:0]     grant_cnt
);

  localparam int IW = $clog2(N_REQ);

  gmem_arb_state_t state, state_nxt;
  logic [IW-1:0]   ptr, g, pick_idx;
  logic [N_REQ-1:0] pick_gnt;
  logic [7:0]      cnt;
  logic            ar_hs, beat;

  logic [N_REQ-1:0][ADDR_W-1:0] araddr_a;
  logic [N_REQ-1:0][7:0]        arlen_a;
  logic [N_REQ-1:0][ID_W-1:0]   arid_a;

  assign araddr_a = s_araddr;
  assign arlen_a  = s_arlen;
  assign arid_a   = s_arid;

  rr_pick #(.N(N_REQ)) u_pick (
    .req (s_arvalid),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  assign ar_hs = (state == ADDR) && m_arready;
  assign beat  = (state == DATA) && m_rvalid && s_rready[g];

  // Data path is a straight broadcast; only the valid bits are steered.
  assign s_rdata  = m_rdata;
  assign s_rid    = m_rid;
  assign s_rlast  = m_rlast;
  assign m_araddr = araddr_a[g];
  assign m_arlen  = arlen_a[g];
  assign m_arid   = arid_a[g];

  // State register, grant/pointer latches, beat counter and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= IW'(N_REQ - 1);
      g         <= '0;
      cnt       <= '0;
      burst_err <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (|s_arvalid) begin
          g   <= pick_idx;
          cnt <= arlen_a[pick_idx];
        end
        DATA: if (beat) begin
          if (m_rlast) begin
            ptr <= g;
            if (cnt != 8'd0) burst_err <= 1'b1;
          end else if (cnt == 8'd0) begin
            burst_err <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Next state and handshake steering; nothing is asserted in IDLE.
  always_comb begin
    state_nxt = state;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    s_arready = '0;
    s_rvalid  = '0;
    case (state)
      IDLE: if (|s_arvalid) state_nxt = ADDR;
      ADDR: begin
        m_arvalid    = 1'b1;
        s_arready[g] = m_arready;
        if (ar_hs) state_nxt = DATA;
      end
      DATA: begin
        m_rready    = s_rready[g];
        s_rvalid[g] = m_rvalid;
        if (beat && m_rlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef GMEM_ARB_STATS_EN
  logic [15:0] gcnt [N_REQ];
  for (genvar i = 0; i < N_REQ; i++) begin : g_stat
    // Saturating count of AR handshakes for requester i.
    always_ff @(posedge clk) begin
      if (rst)
        gcnt[i] <= '0;
      else if (ar_hs && (g == IW'(i)) && (gcnt[i] != 16'hFFFF))
        gcnt[i] <= gcnt[i] + 16'd1;
    end
    assign grant_cnt[i*16 +: 16] = gcnt[i];
  end
`else
  assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_gmem_rd_arbiter.sv
// Directed self-checking bench for gmem_rd_arbiter (N_REQ=2).
module tb_gmem_rd_arbiter;

  localparam int N = 2;
  localparam int AW = 28;
  localparam int DW = 32;
  localparam int IDW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*AW-1:0] s_araddr;
  logic [N*8-1:0]  s_arlen;
  logic [N*IDW-1:0] s_arid;
  logic [N-1:0]    s_arvalid;
  logic [N-1:0]    s_arready;
  logic [DW-1:0]   s_rdata;
  logic [IDW-1:0]  s_rid;
  logic            s_rlast;
  logic [N-1:0]    s_rvalid;
  logic [N-1:0]    s_rready;
  logic [AW-1:0]   m_araddr;
  logic [7:0]      m_arlen;
  logic [IDW-1:0]  m_arid;
  logic            m_arvalid;
  logic            m_arready;
  logic [DW-1:0]   m_rdata;
  logic [IDW-1:0]  m_rid;
  logic            m_rlast;
  logic            m_rvalid;
  logic            m_rready;
  logic            burst_err;
  logic [N*16-1:0] grant_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  gmem_rd_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IDW)) dut (
    .clk(clk), .rst(rst),
    .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arid(s_arid),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rid(s_rid), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arid(m_arid),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rid(m_rid), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .burst_err(burst_err), .grant_cnt(grant_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [AW-1:0] addr, input logic [7:0] len,
                         input logic [IDW-1:0] id);
    s_araddr[r*AW +: AW]   = addr;
    s_arlen[r*8 +: 8]      = len;
    s_arid[r*IDW +: IDW]   = id;
    s_arvalid[r]           = 1'b1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    s_araddr = '0; s_arlen = '0; s_arid = '0; s_arvalid = '0; s_rready = '0;
    m_arready = 1'b0; m_rdata = '0; m_rid = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  // Precondition: FSM in IDLE with requester r's AR fields valid.
  // Drives n_beats R beats with RLAST on beat index last_idx; optionally
  // raises requester 'raise' arvalid on the second beat.
  task automatic do_burst(input int r, input logic [AW-1:0] addr, input logic [7:0] len,
                          input int n_beats, input int last_idx, input int raise,
                          input logic exp_err);
    logic [DW-1:0] d;
    m_arready = 1'b0;
    #1;
    chk("idle_arvalid", 64'(m_arvalid), 64'd0);
    tick;
    chk("addr_arvalid", 64'(m_arvalid), 64'd1);
    chk("addr_araddr", 64'(m_araddr), 64'(addr));
    chk("addr_arlen", 64'(m_arlen), 64'(len));
    chk("addr_arready_wait", 64'(s_arready), 64'd0);
    m_arready = 1'b1;
    #1;
    chk("addr_arready", 64'(s_arready), 64'd1 << r);
    tick;
    m_arready = 1'b0;
    s_arvalid[r] = 1'b0;
    for (int b = 0; b < n_beats; b++) begin
      d = 32'hD000_0000 + 32'(b) + 32'(r * 16);
      m_rvalid = 1'b1;
      m_rdata  = d;
      m_rid    = IDW'(r + 3);
      m_rlast  = (b == last_idx);
      s_rready = N'(1 << r);
      if (b == 1 && raise >= 0) s_arvalid[raise] = 1'b1;
      #1;
      chk("data_rvalid", 64'(s_rvalid), 64'd1 << r);
      chk("data_rready", 64'(m_rready), 64'd1);
      chk("data_rdata", 64'(s_rdata), 64'(d));
      chk("data_rid", 64'(s_rid), 64'(r + 3));
      chk("data_no_arvalid", 64'(m_arvalid), 64'd0);
      tick;
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    s_rready = '0;
    #1;
    chk("end_burst_err", 64'(burst_err), 64'(exp_err));
  endtask

  initial begin
    // 1: reset state and a single 4-beat burst from requester 0
    do_reset;
    #1;
    chk("rst_arvalid", 64'(m_arvalid), 64'd0);
    chk("rst_arready", 64'(s_arready), 64'd0);
    chk("rst_rvalid", 64'(s_rvalid), 64'd0);
    chk("rst_rready", 64'(m_rready), 64'd0);
    chk("rst_err", 64'(burst_err), 64'd0);
    chk("rst_gcnt", 64'(grant_cnt), 64'd0);
    set_req(0, 28'h100, 8'd3, 4'h1);
    do_burst(0, 28'h100, 8'd3, 4, 3, -1, 1'b0);
    // back in IDLE: incoming R data must not be routed
    m_rvalid = 1'b1; s_rready = 2'b11;
    #1;
    chk("t1_idle_rvalid", 64'(s_rvalid), 64'd0);
    chk("t1_idle_rready", 64'(m_rready), 64'd0);
    m_rvalid = 1'b0; s_rready = '0;
    tick;

    // 2: both requesting every time -> grant order 0,1,0
    do_reset;
    set_req(0, 28'h200, 8'd1, 4'h2);
    set_req(1, 28'h300, 8'd0, 4'h3);
    do_burst(0, 28'h200, 8'd1, 2, 1, -1, 1'b0);
    s_arvalid[0] = 1'b1;
    do_burst(1, 28'h300, 8'd0, 1, 0, -1, 1'b0);
    s_arvalid[1] = 1'b1;
    do_burst(0, 28'h200, 8'd1, 2, 1, -1, 1'b0);
    s_arvalid = '0;
    tick;

    // 3: requester 1 arrives during requester 0's DATA phase
    do_reset;
    set_req(0, 28'h400, 8'd2, 4'h4);
    set_req(1, 28'h500, 8'd1, 4'h5);
    s_arvalid[1] = 1'b0;
    do_burst(0, 28'h400, 8'd2, 3, 2, 1, 1'b0);
    do_burst(1, 28'h500, 8'd1, 2, 1, -1, 1'b0);
    tick;

    // 4: early RLAST sets sticky error; a correct burst leaves it set
    do_reset;
    set_req(0, 28'h600, 8'd3, 4'h6);
    do_burst(0, 28'h600, 8'd3, 2, 1, -1, 1'b1);
    m_rvalid = 1'b1; s_rready = 2'b11;
    #1;
    chk("t4_idle_rvalid", 64'(s_rvalid), 64'd0);
    chk("t4_idle_rready", 64'(m_rready), 64'd0);
    m_rvalid = 1'b0; s_rready = '0;
    set_req(0, 28'h640, 8'd1, 4'h6);
    do_burst(0, 28'h640, 8'd1, 2, 1, -1, 1'b1);
    do_reset;
    #1;
    chk("t4_rst_clears_err", 64'(burst_err), 64'd0);
    // late RLAST: counter hits zero on a non-last beat
    set_req(0, 28'h680, 8'd0, 4'h6);
    do_burst(0, 28'h680, 8'd0, 2, 1, -1, 1'b1);

    // 5: reset in the middle of a DATA burst
    do_reset;
    set_req(0, 28'h700, 8'd3, 4'h7);
    tick;
    m_arready = 1'b1;
    tick;
    m_arready = 1'b0; s_arvalid = '0;
    m_rvalid = 1'b1; s_rready = 2'b01;
    #1;
    chk("t5_mid_rvalid", 64'(s_rvalid), 64'd1);
    tick;
    rst = 1'b1; s_arvalid = 2'b11; m_arready = 1'b1; s_rready = 2'b11;
    set_req(0, 28'h720, 8'd0, 4'h7);
    set_req(1, 28'h740, 8'd0, 4'h8);
    tick;
    rst = 1'b0;
    #1;
    chk("t5_arvalid", 64'(m_arvalid), 64'd0);
    chk("t5_arready", 64'(s_arready), 64'd0);
    chk("t5_rvalid", 64'(s_rvalid), 64'd0);
    chk("t5_rready", 64'(m_rready), 64'd0);
    chk("t5_err", 64'(burst_err), 64'd0);
    m_rvalid = 1'b0; m_arready = 1'b0; s_rready = '0;
    do_burst(0, 28'h720, 8'd0, 1, 0, -1, 1'b0);

    // 6: five grants to requester 1
    do_reset;
    for (int k = 0; k < 5; k++) begin
      set_req(1, AW'(28'h800 + k * 16), 8'd0, 4'h9);
      do_burst(1, AW'(28'h800 + k * 16), 8'd0, 1, 0, -1, 1'b0);
    end
`ifdef GMEM_ARB_STATS_EN
    chk("t6_gcnt1", 64'(grant_cnt[31:16]), 64'd5);
    chk("t6_gcnt0", 64'(grant_cnt[15:0]), 64'd0);
`else
    chk("t6_gcnt_off", 64'(grant_cnt), 64'd0);
`endif
    do_reset;
    #1;
    chk("t6_gcnt_rst", 64'(grant_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
